// File: rtl/multi_latch_bank.sv
// multi_latch_bank: NREG edge-triggered capture registers sharing one write
// bus, read out through NPORT independent OR-combining read ports.
//
// Each register captures `in` on a rising edge of its own `latch` level
// (edge detected against a per-register history bit). `clr` zeroes a register
// synchronously and always beats a coincident capture. Read ports are purely
// combinational: port p is the OR of every register whose oe bit is set.
//
// Optional feature (macro MULTI_LATCH_BANK_CONFLICT_EN):
//   adds output `conflict` (NPORT bits). conflict[p] is a sticky flag that
//   sets on any clock where two or more registers are enabled onto port p.
//   With the macro undefined the port and its logic do not exist.
//
// Interface notes: there is no handshake. `latch` and `clr` are level inputs
// sampled on every rising clk; `out` and `valid` are continuously valid.
// Reset is asynchronous and active low.

module multi_latch_bank #(
   parameter int WIDTH = 12,
   parameter int NREG  = 4,
   parameter int NPORT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in,
   input  logic [NREG-1:0]        latch,
   input  logic [NREG-1:0]        clr,
   input  logic [NPORT*NREG-1:0]  oe,
   output logic [NPORT*WIDTH-1:0] out,
   output logic [NREG-1:0]        valid
`ifdef MULTI_LATCH_BANK_CONFLICT_EN
   ,
   output logic [NPORT-1:0]       conflict
`endif
);

   // Stored words and their valid flags.
   logic [WIDTH-1:0] data [NREG];
   logic [NREG-1:0]  valid_q;

   // Previous-clock sample of latch. Resets to ones so that a latch already
   // high when reset releases is not mistaken for a fresh rising edge.
   logic [NREG-1:0]  latch_q;

   // One-clock capture strobe per register.
   logic [NREG-1:0]  capture;

   assign capture = latch & ~latch_q;
   assign valid   = valid_q;

   // Edge history: follows latch every clock, independent of clr, so an edge
   // swallowed by a clear is not replayed later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latch_q <= '1;
      end else begin
         latch_q <= latch;
      end
   end

   // Storage: clear has priority over capture; all capturing registers take
   // the same `in` word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) begin
            data[r] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (clr[r]) begin
               data[r]    <= '0;
               valid_q[r] <= 1'b0;
            end else if (capture[r]) begin
               data[r]    <= in;
               valid_q[r] <= 1'b1;
            end
         end
      end
   end

   // Read ports: wired-OR of every enabled register, zero when none enabled.
   // Reads only stored data, so `in` never reaches `out` directly.
   always_comb begin
      out = '0;
      for (int p = 0; p < NPORT; p++) begin
         for (int r = 0; r < NREG; r++) begin
            if (oe[p*NREG + r]) begin
               out[p*WIDTH +: WIDTH] = out[p*WIDTH +: WIDTH] | data[r];
            end
         end
      end
   end

`ifdef MULTI_LATCH_BANK_CONFLICT_EN
   // Per-port detection of two or more simultaneous enables.
   logic [NPORT-1:0] seen_one;
   logic [NPORT-1:0] multi_en;

   // Scan each port's enables: a second set bit after the first marks overlap.
   always_comb begin
      seen_one = '0;
      multi_en = '0;
      for (int p = 0; p < NPORT; p++) begin
         for (int r = 0; r < NREG; r++) begin
            if (oe[p*NREG + r]) begin
               if (seen_one[p]) begin
                  multi_en[p] = 1'b1;
               end
               seen_one[p] = 1'b1;
            end
         end
      end
   end

   // Sticky conflict flags, only cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         conflict <= '0;
      end else begin
         conflict <= conflict | multi_en;
      end
   end
`endif

endmodule

// File: tb/tb_multi_latch_bank.sv
// Directed testbench for multi_latch_bank (default parameters 12/4/2).
// Builds with or without MULTI_LATCH_BANK_CONFLICT_EN; conflict checks are
// compiled in only when the macro is defined.

module tb_multi_latch_bank;

   localparam int WIDTH = 12;
   localparam int NREG  = 4;
   localparam int NPORT = 2;

   logic                   clk;
   logic                   reset;
   logic [WIDTH-1:0]       in;
   logic [NREG-1:0]        latch;
   logic [NREG-1:0]        clr;
   logic [NPORT*NREG-1:0]  oe;
   logic [NPORT*WIDTH-1:0] out;
   logic [NREG-1:0]        valid;
`ifdef MULTI_LATCH_BANK_CONFLICT_EN
   logic [NPORT-1:0]       conflict;
`endif

   int errors = 0;
   int checks = 0;

   // Expected read values waiting to be compared.
   logic [WIDTH-1:0] exp_q[$];

   multi_latch_bank #(.WIDTH(WIDTH), .NREG(NREG), .NPORT(NPORT)) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .latch    (latch),
      .clr      (clr),
      .oe       (oe),
      .out      (out),
      .valid    (valid)
`ifdef MULTI_LATCH_BANK_CONFLICT_EN
      ,
      .conflict (conflict)
`endif
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Advance n clocks; inputs are then driven 1 unit after the edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive read enables and let the combinational path settle.
   task automatic set_oe(input logic [NPORT*NREG-1:0] v);
      oe = v;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      in    = 12'o1234;
      latch = 4'b0001;
      clr   = 4'b0000;
      oe    = 8'h01;

      // Reset held: everything zero regardless of oe.
      #12;
      check("rst_out", 32'(out), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
`ifdef MULTI_LATCH_BANK_CONFLICT_EN
      check("rst_conflict", 32'(conflict), 32'h0);
`endif

      // Release with latch[0] already high: no capture.
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(3);
      check("hi_at_release_out", 32'(out), 32'h0);
      check("hi_at_release_valid", 32'(valid), 32'h0);
      latch = 4'b0000;
      tick(1);
      check("low_phase_valid", 32'(valid), 32'h0);
      latch = 4'b0001;
      tick(1);
      check("fresh_edge_out", 32'(out), 32'(12'o1234));
      check("fresh_edge_valid", 32'(valid), 32'h1);

      // latch[1] held high five clocks while in changes: one capture only.
      set_oe(8'h00);
      latch = 4'b0010;
      in    = 12'o0007;
      tick(1);
      in = 12'o0070;
      tick(4);
      set_oe(8'h02);
      check("held_latch_r1", 32'(out), 32'(12'o0007));
      set_oe(8'h10);
      check("port1_r0", 32'(out), {8'h0, 12'o1234, 12'o0000});
      check("held_latch_valid", 32'(valid), 32'h3);

      // Clear coincident with rising edge on r2: clear wins, edge consumed.
      latch = 4'b0110;
      clr   = 4'b0100;
      in    = 12'o7777;
      tick(1);
      clr = 4'b0000;
      tick(3);
      check("clr_wins_valid", 32'(valid), 32'h3);
      set_oe(8'h04);
      check("clr_wins_data", 32'(out), 32'h0);

      // Load r0 = 5000, r1 = 0017 for the overlap test.
      latch = 4'b0000;
      tick(1);
      latch = 4'b0001;
      in    = 12'o5000;
      tick(1);
      latch = 4'b0010;
      in    = 12'o0017;
      tick(1);
      latch = 4'b0000;
      tick(1);
      set_oe(8'h23);
      check("or_ports", 32'(out), {8'h0, 12'o0017, 12'o5017});
      in = 12'o7777;
      #1;
      check("no_passthru", 32'(out), {8'h0, 12'o0017, 12'o5017});
      tick(1);
`ifdef MULTI_LATCH_BANK_CONFLICT_EN
      check("conflict_set", 32'(conflict), 32'h1);
`endif
      set_oe(8'h00);
      tick(1);
      check("no_oe_out", 32'(out), 32'h0);
`ifdef MULTI_LATCH_BANK_CONFLICT_EN
      check("conflict_sticky", 32'(conflict), 32'h1);
`endif

      // All four registers capture on the same clock.
      latch = 4'b1111;
      in    = 12'o4321;
      tick(1);
      in = 12'o0000;
      for (int r = 0; r < NREG; r++) exp_q.push_back(12'o4321);
      for (int r = 0; r < NREG; r++) begin
         set_oe(8'(1 << r));
         check($sformatf("multi_cap_r%0d", r), 32'(out[WIDTH-1:0]), 32'(exp_q.pop_front()));
      end
      set_oe(8'h48);
      check("shared_reg_ports", 32'(out), {8'h0, 12'o4321, 12'o4321});
      check("multi_cap_valid", 32'(valid), 32'hF);

      // Clear r3 alone while latch stays high.
      clr = 4'b1000;
      tick(1);
      clr = 4'b0000;
      tick(1);
      check("clr_r3_valid", 32'(valid), 32'h7);
      set_oe(8'h08);
      check("clr_r3_data", 32'(out), 32'h0);

      // Asynchronous reset between edges.
      set_oe(8'h11);
      check("pre_async_out", 32'(out), {8'h0, 12'o4321, 12'o4321});
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_out", 32'(out), 32'h0);
      check("async_valid", 32'(valid), 32'h0);
`ifdef MULTI_LATCH_BANK_CONFLICT_EN
      check("async_conflict", 32'(conflict), 32'h0);
`endif
      #2;
      reset = 1'b1;
      tick(2);
      check("post_async_no_cap", 32'(valid), 32'h0);
      latch = 4'b0000;
      tick(1);
      latch = 4'b0001;
      in    = 12'o0123;
      tick(1);
      check("post_async_cap_out", 32'(out), {8'h0, 12'o0123, 12'o0123});
      check("post_async_cap_valid", 32'(valid), 32'h1);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL exp_q_drain: got %0d expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
